// File: rtl/ex_mc_sequencer_if.sv
// Handshake bundle between the EX stage and the multi-cycle sequencer.
// The DUT side uses the slave modport; the pipeline/bench side uses master.
interface ex_mc_sequencer_if;
  logic        ex_valid;
  logic [6:0]  EX;
  logic        flush;
  logic        busy;
  logic        res_valid;
  logic        res_fp;
  logic        add_sub;
  logic [6:0]  hold_ctrl;
  logic [3:0]  cyc_left;
  logic [15:0] mc_count;

  modport master (
    output ex_valid, EX, flush,
    input  busy, res_valid, res_fp, add_sub, hold_ctrl, cyc_left, mc_count
  );

  modport slave (
    input  ex_valid, EX, flush,
    output busy, res_valid, res_fp, add_sub, hold_ctrl, cyc_left, mc_count
  );
endinterface

// File: rtl/ex_mc_sequencer.sv
// Multi-cycle execute-op sequencer: decodes the EX bus into a latency, stalls
// the pipeline while the FU works and pulses res_valid when the result is ready.
module ex_mc_sequencer #(
  parameter int unsigned LAT_IMUL = 5,
  parameter int unsigned LAT_IDIV = 0,
  parameter int unsigned LAT_FCVT = 6,
  parameter int unsigned LAT_FADD = 7,
  parameter int unsigned LAT_FMUL = 5,
  parameter int unsigned LAT_FDIV = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  ex_mc_sequencer_if.slave       bus
);

  localparam logic [3:0] L_IMUL = 4'(LAT_IMUL);
  localparam logic [3:0] L_IDIV = 4'(LAT_IDIV);
  localparam logic [3:0] L_FCVT = 4'(LAT_FCVT);
  localparam logic [3:0] L_FADD = 4'(LAT_FADD);
  localparam logic [3:0] L_FMUL = 4'(LAT_FMUL);
  localparam logic [3:0] L_FDIV = 4'(LAT_FDIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cyc_left_q, cyc_left_d;
  logic [6:0]  hold_ctrl_q, hold_ctrl_d;
  logic        add_sub_q, add_sub_d;
  logic        res_fp_q, res_fp_d;
  logic [15:0] mc_count_q, mc_count_d;

  logic        is_int, is_fp;
  logic [3:0]  lat;
  logic        issue;

  assign is_int = bus.EX[0];
  assign is_fp  = !bus.EX[0] && bus.EX[4];

  // Latency table; anything not listed runs as a single-cycle op (L=0).
  always_comb begin
    lat = 4'd0;
    if (is_int) begin
      unique case (bus.EX[4:1])
        4'b0011:         lat = L_IMUL;
        4'b0100, 4'b0101: lat = L_IDIV;
        default:         lat = 4'd0;
      endcase
    end else if (is_fp) begin
      unique case (bus.EX[3:1])
        3'b000, 3'b001: lat = L_FCVT;
        3'b011, 3'b100: lat = L_FADD;
        3'b101:         lat = L_FMUL;
        3'b110:         lat = L_FDIV;
        default:        lat = 4'd0;
      endcase
    end
  end

  assign issue = rst && (state_q == IDLE) && bus.ex_valid && !bus.flush && (lat != 4'd0);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cyc_left_d  = cyc_left_q;
    hold_ctrl_d = hold_ctrl_q;
    add_sub_d   = add_sub_q;
    res_fp_d    = res_fp_q;
    mc_count_d  = mc_count_q;

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          hold_ctrl_d = bus.EX;
          add_sub_d   = (bus.EX[3:1] != 3'b100);
          res_fp_d    = is_fp;
          cyc_left_d  = lat - 4'd1;
          state_d     = (lat > 4'd1) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d    = IDLE;
          cyc_left_d = 4'd0;
        end else if (cyc_left_q == 4'd1) begin
          state_d    = DONE;
          cyc_left_d = 4'd0;
        end else begin
          cyc_left_d = cyc_left_q - 4'd1;
        end
      end
      DONE: begin
        // The EX bus here still carries the stalled instruction, so never issue.
        state_d = IDLE;
        if (!bus.flush) mc_count_d = mc_count_q + 16'd1;
      end
      default: begin
        state_d    = IDLE;
        cyc_left_d = 4'd0;
      end
    endcase
  end

  // NOTE: reset is synchronous and active-low; state registers use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_left_q  <= 4'd0;
      hold_ctrl_q <= 7'd0;
      add_sub_q   <= 1'b1;
      res_fp_q    <= 1'b0;
      mc_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cyc_left_q  <= cyc_left_d;
      hold_ctrl_q <= hold_ctrl_d;
      add_sub_q   <= add_sub_d;
      res_fp_q    <= res_fp_d;
      mc_count_q  <= mc_count_d;
    end
  end

  // busy covers the issue cycle combinationally; flush drops it in the same cycle.
  assign bus.busy      = issue || (rst && (state_q == RUN) && !bus.flush);
  assign bus.res_valid = rst && (state_q == DONE) && !bus.flush;
  assign bus.res_fp    = res_fp_q;
  assign bus.add_sub   = add_sub_q;
  assign bus.hold_ctrl = hold_ctrl_q;
  assign bus.cyc_left  = cyc_left_q;
  assign bus.mc_count  = mc_count_q;

endmodule

// File: tb/tb_ex_mc_sequencer.sv
// Directed bench for ex_mc_sequencer: inputs change at negedge, outputs are
// checked 1 time unit later, well clear of the posedge.
module tb_ex_mc_sequencer;

  localparam logic [6:0] EX_FADD = 7'b0010110;
  localparam logic [6:0] EX_FSUB = 7'b0011000;
  localparam logic [6:0] EX_FMUL = 7'b0011010;
  localparam logic [6:0] EX_IMUL = 7'b0000111;
  localparam logic [6:0] EX_IADD = 7'b0000011;
  localparam logic [6:0] EX_IDIV = 7'b0001001;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  ex_mc_sequencer_if bus ();

  ex_mc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] ex, input logic fl);
    bus.ex_valid = v;
    bus.EX       = ex;
    bus.flush    = fl;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // Reset held two cycles with a valid fadd on the bus.
    rst = 1'b0;
    drive(1'b1, EX_FADD, 1'b0);
    next_cycle();
    drive(1'b1, EX_FADD, 1'b0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_mc_count",  32'(bus.mc_count),  32'd0);
    check("rst_add_sub",   32'(bus.add_sub),   32'd1);
    check("rst_hold_ctrl", 32'(bus.hold_ctrl), 32'd0);
    check("rst_cyc_left",  32'(bus.cyc_left),  32'd0);
    next_cycle();

    // fadd: issue cycle 0, busy 0..6, res_valid cycle 7.
    rst = 1'b1;
    drive(1'b1, EX_FADD, 1'b0);
    check("fadd_c0_busy", 32'(bus.busy), 32'd1);
    check("fadd_c0_rv",   32'(bus.res_valid), 32'd0);
    next_cycle();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, EX_FADD, 1'b0);
      check($sformatf("fadd_c%0d_busy", c), 32'(bus.busy), 32'd1);
      check($sformatf("fadd_c%0d_rv", c), 32'(bus.res_valid), 32'd0);
      check($sformatf("fadd_c%0d_left", c), 32'(bus.cyc_left), 32'(7 - c));
      next_cycle();
    end
    drive(1'b1, EX_FADD, 1'b0);
    check("fadd_c7_busy",   32'(bus.busy),      32'd0);
    check("fadd_c7_rv",     32'(bus.res_valid), 32'd1);
    check("fadd_c7_res_fp", 32'(bus.res_fp),    32'd1);
    check("fadd_c7_addsub", 32'(bus.add_sub),   32'd1);
    check("fadd_c7_hold",   32'(bus.hold_ctrl), 32'(EX_FADD));
    next_cycle();
    drive(1'b0, EX_FADD, 1'b0);
    check("fadd_c8_rv",     32'(bus.res_valid), 32'd0);
    check("fadd_c8_busy",   32'(bus.busy),      32'd0);
    check("fadd_c8_count",  32'(bus.mc_count),  32'd1);
    check("fadd_c8_addsub", 32'(bus.add_sub),   32'd1);
    next_cycle();

    // fsub then imul back-to-back, EX held during the stall.
    drive(1'b1, EX_FSUB, 1'b0);
    check("fsub_c0_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    drive(1'b1, EX_FSUB, 1'b0);
    check("fsub_c1_addsub", 32'(bus.add_sub),   32'd0);
    check("fsub_c1_hold",   32'(bus.hold_ctrl), 32'(EX_FSUB));
    next_cycle();
    for (int c = 2; c <= 6; c++) begin
      drive(1'b1, EX_FSUB, 1'b0);
      check($sformatf("fsub_c%0d_busy", c), 32'(bus.busy), 32'd1);
      next_cycle();
    end
    drive(1'b1, EX_FSUB, 1'b0);
    check("fsub_c7_rv",     32'(bus.res_valid), 32'd1);
    check("fsub_c7_busy",   32'(bus.busy),      32'd0);
    check("fsub_c7_res_fp", 32'(bus.res_fp),    32'd1);
    next_cycle();
    drive(1'b1, EX_IMUL, 1'b0);
    check("imul_c8_busy",  32'(bus.busy),      32'd1);
    check("imul_c8_rv",    32'(bus.res_valid), 32'd0);
    check("imul_c8_count", 32'(bus.mc_count),  32'd2);
    next_cycle();
    for (int c = 9; c <= 12; c++) begin
      drive(1'b1, EX_FADD, 1'b0);
      check($sformatf("imul_c%0d_busy", c), 32'(bus.busy), 32'd1);
      check($sformatf("imul_c%0d_hold", c), 32'(bus.hold_ctrl), 32'(EX_IMUL));
      next_cycle();
    end
    drive(1'b1, EX_FADD, 1'b0);
    check("imul_c13_rv",     32'(bus.res_valid), 32'd1);
    check("imul_c13_busy",   32'(bus.busy),      32'd0);
    check("imul_c13_res_fp", 32'(bus.res_fp),    32'd0);
    next_cycle();
    drive(1'b0, EX_FADD, 1'b0);
    check("imul_c14_busy",  32'(bus.busy),     32'd0);
    check("imul_c14_count", 32'(bus.mc_count), 32'd3);
    check("imul_c14_left",  32'(bus.cyc_left), 32'd0);
    next_cycle();

    // Single-cycle ops: int add and idiv (LAT_IDIV=0) never stall.
    drive(1'b1, EX_IADD, 1'b0);
    check("iadd_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    drive(1'b1, EX_IDIV, 1'b0);
    check("idiv_busy",     32'(bus.busy),      32'd0);
    check("iadd_next_rv",  32'(bus.res_valid), 32'd0);
    next_cycle();
    drive(1'b0, EX_IDIV, 1'b0);
    check("idiv_next_rv",   32'(bus.res_valid), 32'd0);
    check("idiv_next_left", 32'(bus.cyc_left),  32'd0);
    check("idiv_next_hold", 32'(bus.hold_ctrl), 32'(EX_IMUL));
    next_cycle();

    // Flush together with a would-be issue in IDLE: nothing issues.
    drive(1'b1, EX_FADD, 1'b1);
    check("flush_idle_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    drive(1'b0, EX_FADD, 1'b0);
    check("flush_idle_next_busy", 32'(bus.busy), 32'd0);
    check("flush_idle_next_hold", 32'(bus.hold_ctrl), 32'(EX_IMUL));
    next_cycle();

    // fmul with flush at cycle 2.
    drive(1'b1, EX_FMUL, 1'b0);
    check("fmulf_c0_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    drive(1'b1, EX_FMUL, 1'b0);
    check("fmulf_c1_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    drive(1'b1, EX_FMUL, 1'b1);
    check("fmulf_c2_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    for (int c = 3; c <= 6; c++) begin
      drive(1'b0, EX_FMUL, 1'b0);
      check($sformatf("fmulf_c%0d_busy", c), 32'(bus.busy), 32'd0);
      check($sformatf("fmulf_c%0d_rv", c), 32'(bus.res_valid), 32'd0);
      next_cycle();
    end
    drive(1'b0, EX_FMUL, 1'b0);
    check("fmulf_count", 32'(bus.mc_count), 32'd3);
    check("fmulf_left",  32'(bus.cyc_left), 32'd0);
    next_cycle();

    // fmul with flush in DONE: result suppressed, count unchanged.
    drive(1'b1, EX_FMUL, 1'b0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, EX_FMUL, 1'b0);
      check($sformatf("fmuld_c%0d_busy", c), 32'(bus.busy), 32'd1);
      next_cycle();
    end
    drive(1'b1, EX_FMUL, 1'b1);
    check("fmuld_c5_rv", 32'(bus.res_valid), 32'd0);
    next_cycle();
    drive(1'b0, EX_FMUL, 1'b0);
    check("fmuld_c6_count", 32'(bus.mc_count), 32'd3);
    check("fmuld_c6_rv",    32'(bus.res_valid), 32'd0);
    next_cycle();

    // Counter wrap: preload 16'hFFFF, one fmul completion wraps to 0.
    force dut.mc_count_q = 16'hFFFF;
    next_cycle();
    release dut.mc_count_q;
    drive(1'b0, EX_FMUL, 1'b0);
    check("wrap_preload", 32'(bus.mc_count), 32'h0000FFFF);
    next_cycle();
    drive(1'b1, EX_FMUL, 1'b0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, EX_FMUL, 1'b0);
      next_cycle();
    end
    drive(1'b1, EX_FMUL, 1'b0);
    check("wrap_c5_rv",    32'(bus.res_valid), 32'd1);
    check("wrap_c5_count", 32'(bus.mc_count),  32'h0000FFFF);
    next_cycle();
    drive(1'b0, EX_FMUL, 1'b0);
    check("wrap_c6_count", 32'(bus.mc_count), 32'd0);
    next_cycle();

    // Reset in the middle of a fsub: back to reset values, no result.
    drive(1'b1, EX_FSUB, 1'b0);
    check("rstrun_c0_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    drive(1'b1, EX_FSUB, 1'b0);
    check("rstrun_c1_addsub", 32'(bus.add_sub), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, EX_FSUB, 1'b0);
    check("rstrun_c2_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, EX_FSUB, 1'b0);
    check("rstrun_busy",   32'(bus.busy),      32'd0);
    check("rstrun_left",   32'(bus.cyc_left),  32'd0);
    check("rstrun_addsub", 32'(bus.add_sub),   32'd1);
    check("rstrun_hold",   32'(bus.hold_ctrl), 32'd0);
    check("rstrun_count",  32'(bus.mc_count),  32'd0);
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, EX_FSUB, 1'b0);
      check($sformatf("rstrun_after%0d_rv", c), 32'(bus.res_valid), 32'd0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
